// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU for the mMIPS execute stage.
// Single-cycle logic/add/shift/compare/clamp ops complete in one cycle;
// multiply and divide iterate one bit per cycle (WIDTH RUN steps + FIX).
// Shifts operate on operand s (a); LUI operates on operand t (b).
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   start         request, sampled only while busy=0
//   ctrl[5:0]     opcode, a/b operands s/t, all sampled with start
//   r, r2         low word / quotient, high word / remainder
//   z             r == 0
//   busy          iterative op in progress
//   done          one-cycle pulse when r/r2/z/err update
//   err           divide by zero or invalid opcode, held until next done
module alu_mc #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [5:0]       ctrl,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] r,
   output logic [WIDTH-1:0] r2,
   output logic             z,
   output logic             busy,
   output logic             done,
   output logic             err
);
   localparam int unsigned CW = $clog2(WIDTH + 1);
   localparam int unsigned HW = WIDTH / 2;

   localparam logic [5:0] OP_AND   = 6'h00;
   localparam logic [5:0] OP_OR    = 6'h01;
   localparam logic [5:0] OP_ADD   = 6'h02;
   localparam logic [5:0] OP_ADDU  = 6'h03;
   localparam logic [5:0] OP_XOR   = 6'h04;
   localparam logic [5:0] OP_SUB   = 6'h06;
   localparam logic [5:0] OP_SLT   = 6'h07;
   localparam logic [5:0] OP_SLTU  = 6'h08;
   localparam logic [5:0] OP_LUI   = 6'h09;
   localparam logic [5:0] OP_SLL1  = 6'h0A;
   localparam logic [5:0] OP_SLL2  = 6'h0B;
   localparam logic [5:0] OP_SLL8  = 6'h0C;
   localparam logic [5:0] OP_SRL1  = 6'h0D;
   localparam logic [5:0] OP_SRL2  = 6'h0E;
   localparam logic [5:0] OP_SRL8  = 6'h0F;
   localparam logic [5:0] OP_SRA1  = 6'h10;
   localparam logic [5:0] OP_SRA2  = 6'h11;
   localparam logic [5:0] OP_SRA8  = 6'h12;
   localparam logic [5:0] OP_MULTU = 6'h13;
   localparam logic [5:0] OP_DIVU  = 6'h14;
   localparam logic [5:0] OP_MULT  = 6'h15;
   localparam logic [5:0] OP_DIV   = 6'h16;
   localparam logic [5:0] OP_CLAMP = 6'h30;

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t           state, state_n;
   logic [CW-1:0]    count, count_n;
   logic [WIDTH-1:0] hi, hi_n;        // product high / partial remainder
   logic [WIDTH-1:0] lo, lo_n;        // multiplier / quotient shift register
   logic [WIDTH-1:0] opd, opd_n;      // multiplicand or divisor magnitude
   logic [WIDTH-1:0] s_save, s_save_n;
   logic             is_div, is_div_n;
   logic             neg_lo, neg_lo_n; // negate product / quotient in FIX
   logic             neg_hi, neg_hi_n; // negate remainder in FIX
   logic             dz, dz_n;
   logic [WIDTH-1:0] r_n, r2_n;
   logic             z_n, busy_n, done_n, err_n;

   // Single-cycle result; invalid opcodes leave sc_res at zero.
   logic [WIDTH-1:0] sc_res;
   logic             sc_hit;
   always_comb begin
      sc_res = '0;
      sc_hit = 1'b1;
      case (ctrl)
         OP_AND:   sc_res = a & b;
         OP_OR:    sc_res = a | b;
         OP_ADD,
         OP_ADDU:  sc_res = a + b;
         OP_XOR:   sc_res = a ^ b;
         OP_SUB:   sc_res = a - b;
         OP_SLT:   sc_res = WIDTH'($signed(a) < $signed(b));
         OP_SLTU:  sc_res = WIDTH'(a < b);
         OP_LUI:   sc_res = b << HW;
         OP_SLL1:  sc_res = a << 1;
         OP_SLL2:  sc_res = a << 2;
         OP_SLL8:  sc_res = a << 8;
         OP_SRL1:  sc_res = a >> 1;
         OP_SRL2:  sc_res = a >> 2;
         OP_SRL8:  sc_res = a >> 8;
         OP_SRA1:  sc_res = $unsigned($signed(a) >>> 1);
         OP_SRA2:  sc_res = $unsigned($signed(a) >>> 2);
         OP_SRA8:  sc_res = $unsigned($signed(a) >>> 8);
         OP_CLAMP: begin
            if (a[WIDTH-1])
               sc_res = '0;
            else if (a > WIDTH'(255))
               sc_res = WIDTH'(255);
            else
               sc_res = a;
         end
         default:  sc_hit = 1'b0;
      endcase
   end

   // Iterative op decode and operand magnitudes.
   logic             it_hit, it_div, it_signed;
   logic [WIDTH-1:0] a_mag, b_mag;
   assign it_div    = (ctrl == OP_DIVU) || (ctrl == OP_DIV);
   assign it_signed = (ctrl == OP_MULT) || (ctrl == OP_DIV);
   assign it_hit    = it_div || (ctrl == OP_MULTU) || (ctrl == OP_MULT);
   assign a_mag     = (it_signed && a[WIDTH-1]) ? -a : a;
   assign b_mag     = (it_signed && b[WIDTH-1]) ? -b : b;

   // One shift-add multiply step and one restoring divide step.
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH-1:0] rem_dif;
   logic             take;
   assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opd} : '0);
   assign rem_sh  = {hi, lo[WIDTH-1]};
   assign rem_dif = rem_sh[WIDTH-1:0] - opd;
   assign take    = rem_sh >= {1'b0, opd};

   // Sign correction and final result selection for FIX.
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   fix_r, fix_r2;
   logic               fix_err;
   always_comb begin
      prod_fix = neg_lo ? -{hi, lo} : {hi, lo};
      fix_r    = prod_fix[WIDTH-1:0];
      fix_r2   = prod_fix[2*WIDTH-1:WIDTH];
      fix_err  = 1'b0;
      if (is_div) begin
         if (dz) begin
            fix_r   = '1;
            fix_r2  = s_save;
            fix_err = 1'b1;
         end else begin
            fix_r  = neg_lo ? -lo : lo;
            fix_r2 = neg_hi ? -hi : hi;
         end
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_n  = state;
      count_n  = count;
      hi_n     = hi;
      lo_n     = lo;
      opd_n    = opd;
      s_save_n = s_save;
      is_div_n = is_div;
      neg_lo_n = neg_lo;
      neg_hi_n = neg_hi;
      dz_n     = dz;
      r_n      = r;
      r2_n     = r2;
      z_n      = z;
      busy_n   = busy;
      done_n   = 1'b0;
      err_n    = err;
      case (state)
         IDLE: begin
            if (start) begin
               if (it_hit) begin
                  state_n  = RUN;
                  busy_n   = 1'b1;
                  count_n  = CW'(WIDTH);
                  hi_n     = '0;
                  lo_n     = it_div ? a_mag : b_mag;
                  opd_n    = it_div ? b_mag : a_mag;
                  s_save_n = a;
                  is_div_n = it_div;
                  neg_lo_n = it_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                  neg_hi_n = it_signed && a[WIDTH-1];
                  dz_n     = it_div && (b == '0);
               end else begin
                  r_n    = sc_res;
                  r2_n   = '0;
                  z_n    = (sc_res == '0);
                  err_n  = !sc_hit;
                  done_n = 1'b1;
               end
            end
         end
         RUN: begin
            if (is_div) begin
               hi_n = take ? rem_dif : rem_sh[WIDTH-1:0];
               lo_n = {lo[WIDTH-2:0], take};
            end else begin
               hi_n = mul_sum[WIDTH:1];
               lo_n = {mul_sum[0], lo[WIDTH-1:1]};
            end
            count_n = count - CW'(1);
            if (count == CW'(1))
               state_n = FIX;
         end
         FIX: begin
            r_n     = fix_r;
            r2_n    = fix_r2;
            z_n     = (fix_r == '0);
            err_n   = fix_err;
            done_n  = 1'b1;
            busy_n  = 1'b0;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         count  <= '0;
         hi     <= '0;
         lo     <= '0;
         opd    <= '0;
         s_save <= '0;
         is_div <= 1'b0;
         neg_lo <= 1'b0;
         neg_hi <= 1'b0;
         dz     <= 1'b0;
         r      <= '0;
         r2     <= '0;
         z      <= 1'b1;
         busy   <= 1'b0;
         done   <= 1'b0;
         err    <= 1'b0;
      end else begin
         state  <= state_n;
         count  <= count_n;
         hi     <= hi_n;
         lo     <= lo_n;
         opd    <= opd_n;
         s_save <= s_save_n;
         is_div <= is_div_n;
         neg_lo <= neg_lo_n;
         neg_hi <= neg_hi_n;
         dz     <= dz_n;
         r      <= r_n;
         r2     <= r2_n;
         z      <= z_n;
         busy   <= busy_n;
         done   <= done_n;
         err    <= err_n;
      end
   end

endmodule
